rssb_sequencer: RTL and testbench

Multi-cycle control sequencer for the RSSB (reverse-subtract, skip-if-borrow) datapath. It drives the register-write strobes (op1, op2/accumulator, data memory, PC) and the PC-increment mux select, stepping each instruction through fixed phases. Adds run/step/stop control, halt-code detection and a retired-instruction counter. Sits beside the datapath in the `rssb` top, replacing free-running strobe generation with a handshaked FSM.

---
 rtl/rssb_sequencer.sv | 130 +++++++++++++
 tb/tb_rssb_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rssb_sequencer.sv
// +-----------------------------------------------------------------------------+
// | rssb_sequencer: six-phase Moore control FSM for the RSSB datapath, with     |
// | run/step/stop control, halt-code detection and a saturating retire counter. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module rssb_sequencer #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] HALT_CODE = {WIDTH{1'b1}},
   parameter int               CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 step_mode,
   input  logic                 stop,
   input  logic [WIDTH-1:0]     rom_data,
   input  logic                 neg,
   output logic                 write_op1,
   output logic                 write_op2,
   output logic                 write_mem,
   output logic                 write_pc,
   output logic                 sel_pc,
   output logic                 busy,
   output logic                 halted,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_READ   = 3'd3,
      S_EXEC   = 3'd4,
      S_ACC    = 3'd5,
      S_UPDPC  = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

   state_t               state_q, state_d;
   logic                 stop_q, stop_d;
   logic                 neg_q, neg_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         stop_q  <= 1'b0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         stop_q  <= stop_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stop_d    = stop_q;
      neg_d     = neg_q;
      cnt_d     = cnt_q;
      write_op1 = 1'b0;
      write_op2 = 1'b0;
      write_mem = 1'b0;
      write_pc  = 1'b0;
      sel_pc    = 1'b0;
      busy      = 1'b0;
      halted    = 1'b0;
      done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) state_d = S_FETCH;
         end
         S_FETCH: begin
            busy    = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            busy    = 1'b1;
            state_d = (rom_data == HALT_CODE) ? S_HALT : S_READ;
         end
         S_READ: begin
            busy      = 1'b1;
            write_op1 = 1'b1;
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            busy      = 1'b1;
            write_mem = 1'b1;
            neg_d     = neg;
            state_d   = S_ACC;
         end
         S_ACC: begin
            busy      = 1'b1;
            write_op2 = 1'b1;
            state_d   = S_UPDPC;
         end
         S_UPDPC: begin
            busy     = 1'b1;
            write_pc = 1'b1;
            sel_pc   = neg_q;
            done     = 1'b1;
            if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + CNT_WIDTH'(1);
            state_d  = (stop_q || step_mode) ? S_IDLE : S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A stop request survives until the instruction boundary returns us to IDLE.
      if (state_d == S_IDLE)  stop_d = 1'b0;
      else if (busy && stop)  stop_d = 1'b1;
   end

   assign instr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rssb_sequencer.sv
// +-----------------------------------------------------------------------------+
// | tb_rssb_sequencer: drives a behavioural RSSB datapath from the sequencer    |
// | strobes and compares against an instruction-level reference model.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_rssb_sequencer;

   localparam int         W    = 8;
   localparam int         CW   = 3;
   localparam logic [7:0] HALT = 8'hFF;

   logic          clk = 1'b0;
   logic          rst, start, step_mode, stop, neg;
   logic [W-1:0]  rom_data;
   logic          write_op1, write_op2, write_mem, write_pc, sel_pc;
   logic          busy, halted, done;
   logic [CW-1:0] instr_count;

   rssb_sequencer #(.WIDTH(W), .HALT_CODE(HALT), .CNT_WIDTH(CW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .stop(stop),
      .rom_data(rom_data), .neg(neg),
      .write_op1(write_op1), .write_op2(write_op2), .write_mem(write_mem),
      .write_pc(write_pc), .sel_pc(sel_pc), .busy(busy), .halted(halted),
      .done(done), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   logic [7:0] obs;
   assign obs = {write_op1, write_op2, write_mem, write_pc, sel_pc, busy, halted, done};

   // Datapath environment and reference-model state
   logic [7:0] rom   [256];
   logic [7:0] d_mem [256];
   logic [7:0] m_mem [256];
   logic [7:0] d_acc, d_op1, d_pc, m_acc, m_pc;
   int         m_cnt;
   logic       ld_en = 1'b0;
   logic       neg_noise = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   // Outside EXEC the borrow input carries noise the sequencer must ignore.
   assign neg = write_mem ? (d_op1 < d_acc) : neg_noise;
   always @(negedge clk) neg_noise <= 1'($urandom % 2);

   always @(posedge clk) begin
      rom_data <= rom[d_pc];
      if (ld_en) begin
         d_mem <= m_mem;
         d_acc <= m_acc;
         d_pc  <= m_pc;
         d_op1 <= 8'h00;
      end else begin
         if (write_op1) d_op1 <= d_mem[rom_data];
         if (write_mem) d_mem[rom_data] <= d_op1 - d_acc;
         if (write_op2) d_acc <= d_mem[rom_data];
         if (write_pc)  d_pc  <= d_pc + (sel_pc ? 8'd2 : 8'd1);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; step_mode = 1'b0;
      tick(); tick();
      check_val("rst_outs", {24'd0, obs}, 32'h00);
      check_val("rst_count", {29'd0, instr_count}, 32'd0);
      rst   = 1'b0;
      m_cnt = 0;
      m_pc  = 8'h00;
   endtask

   task automatic load_prog();
      m_pc  = 8'h00;
      ld_en = 1'b1;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic start_pulse(input bit with_stop);
      start = 1'b1; stop = with_stop;
      tick();
      start = 1'b0; stop = 1'b0;
   endtask

   // One instruction, entered in its FETCH cycle; stop_ph (1..5) pulses stop in that phase.
   task automatic run_instr(input int stop_ph, output bit hit_halt);
      logic [7:0] a, r, exp;
      bit         nb;
      a        = rom[m_pc];
      hit_halt = (a == HALT);
      nb       = (m_mem[a] < m_acc);
      r        = m_mem[a] - m_acc;
      for (int ph = 1; ph <= 6; ph++) begin
         case (ph)
            1, 2:    exp = 8'h04;
            3:       exp = hit_halt ? 8'h02 : 8'h84;
            4:       exp = 8'h24;
            5:       exp = 8'h44;
            default: exp = {4'b0001, nb, 3'b101};
         endcase
         check_val($sformatf("phase%0d@pc%0h", ph, m_pc), {24'd0, obs}, {24'd0, exp});
         if (hit_halt && ph == 3) break;
         start = 1'($urandom % 2);
         stop  = (ph == stop_ph);
         tick();
      end
      start = 1'b0; stop = 1'b0;
      if (!hit_halt) begin
         m_mem[a] = r;
         m_acc    = r;
         m_pc     = m_pc + (nb ? 8'd2 : 8'd1);
         if (m_cnt < (1 << CW) - 1) m_cnt++;
         check_val("pc", {24'd0, d_pc}, {24'd0, m_pc});
         check_val("acc", {24'd0, d_acc}, {24'd0, m_acc});
         check_val("mem", {24'd0, d_mem[a]}, {24'd0, m_mem[a]});
         check_val("count", {29'd0, instr_count}, 32'(m_cnt));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit h;
      int n;
      rst = 1'b1; start = 1'b0; stop = 1'b0; step_mode = 1'b0;
      for (int i = 0; i < 256; i++) begin rom[i] = 8'h00; m_mem[i] = 8'h00; end
      m_acc = 8'h00;
      do_reset();

      // Non-borrow, single step
      rom[0] = 8'h05; m_mem[5] = 8'd10; m_acc = 8'd3; step_mode = 1'b1;
      load_prog(); start_pulse(1'b0); run_instr(0, h);
      check_val("nb_idle", {24'd0, obs}, 32'h00);
      check_val("nb_mem5", {24'd0, d_mem[5]}, 32'd7);
      check_val("nb_acc", {24'd0, d_acc}, 32'd7);
      check_val("nb_pc", {24'd0, d_pc}, 32'd1);

      // Borrow / skip
      do_reset();
      m_mem[5] = 8'd2; m_acc = 8'd9; step_mode = 1'b1;
      load_prog(); start_pulse(1'b0); run_instr(0, h);
      check_val("b_mem5", {24'd0, d_mem[5]}, 32'hF9);
      check_val("b_pc", {24'd0, d_pc}, 32'd2);

      // Step mode: two starts, two instructions
      do_reset();
      rom[0] = 8'h05; rom[1] = 8'h06; m_mem[5] = 8'd20; m_mem[6] = 8'd30; m_acc = 8'd1;
      step_mode = 1'b1;
      load_prog(); start_pulse(1'b0); run_instr(0, h);
      for (int k = 0; k < 3; k++) begin
         check_val("step_idle", {24'd0, obs}, 32'h00);
         tick();
      end
      start_pulse(1'b0); run_instr(0, h);
      check_val("step_idle2", {24'd0, obs}, 32'h00);
      check_val("step_count", {29'd0, instr_count}, 32'd2);

      // Stop during READ of instruction 3, then start+stop in IDLE
      do_reset();
      for (int i = 0; i < 16; i++) rom[i] = 8'h10 + 8'(i);
      for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
      m_acc = 8'h00;
      load_prog(); start_pulse(1'b0);
      run_instr(0, h); run_instr(0, h); run_instr(3, h);
      check_val("stop_idle", {24'd0, obs}, 32'h00);
      check_val("stop_count", {29'd0, instr_count}, 32'd3);
      start_pulse(1'b1);
      check_val("startstop_idle", {24'd0, obs}, 32'h00);
      tick();
      check_val("startstop_idle2", {24'd0, obs}, 32'h00);

      // Halt on third word; start ignored afterwards
      do_reset();
      rom[0] = 8'd10; rom[1] = 8'd10; rom[2] = HALT; m_mem[10] = 8'h33; m_acc = 8'h00;
      load_prog(); start_pulse(1'b0);
      run_instr(0, h); run_instr(0, h); run_instr(0, h);
      check_val("halt_flag", {31'd0, h}, 32'd1);
      check_val("halt_count", {29'd0, instr_count}, 32'd2);
      check_val("halt_pc", {24'd0, d_pc}, 32'd2);
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_val("halt_sticky", {24'd0, obs}, 32'h02);
      end
      start = 1'b0;

      // Asynchronous reset in the middle of EXEC
      do_reset();
      rom[0] = 8'h05; m_mem[5] = 8'h44; m_acc = 8'h04;
      load_prog(); start_pulse(1'b0);
      tick(); tick(); tick();
      check_val("exec_wmem", {31'd0, write_mem}, 32'd1);
      #2 rst = 1'b1;
      #1 check_val("async_wmem", {31'd0, write_mem}, 32'd0);
      tick(); rst = 1'b0; tick();
      check_val("arst_outs", {24'd0, obs}, 32'h00);
      check_val("arst_count", {29'd0, instr_count}, 32'd0);
      check_val("arst_mem5", {24'd0, d_mem[5]}, 32'h44);

      // Counter saturation over nine back-to-back instructions
      do_reset();
      for (int i = 0; i < 256; i++) begin rom[i] = 8'h20; m_mem[i] = 8'($urandom); end
      m_acc = 8'h00;
      load_prog(); start_pulse(1'b0);
      for (int i = 1; i <= 9; i++) run_instr((i == 9) ? 2 : 0, h);
      check_val("sat_count", {29'd0, instr_count}, 32'd7);
      check_val("sat_idle", {24'd0, obs}, 32'h00);

      // Randomized programs
      for (int it = 0; it < 25; it++) begin
         do_reset();
         for (int i = 0; i < 256; i++) begin
            rom[i]   = ($urandom_range(0, 11) == 0) ? HALT : 8'($urandom_range(0, 254));
            m_mem[i] = 8'($urandom);
         end
         m_acc     = 8'($urandom);
         step_mode = ($urandom_range(0, 3) == 0);
         n         = $urandom_range(1, 6);
         load_prog(); start_pulse(1'b0);
         h = 1'b0;
         for (int i = 1; i <= n; i++) begin
            run_instr((i == n) ? $urandom_range(1, 5) : 0, h);
            if (h) break;
            if (step_mode) begin
               check_val("r_step_idle", {24'd0, obs}, 32'h00);
               if (i < n) start_pulse(1'b0);
            end
         end
         if (h) begin
            tick();
            check_val("r_halt", {24'd0, obs}, 32'h02);
         end else begin
            check_val("r_idle", {24'd0, obs}, 32'h00);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
